ula_fsm_param: RTL and testbench
================================

# ula_fsm_param

Parametrised successor of the button-driven ALU sequencer. Operand width is generic, with an 8-operation ALU and registered result/flags. A multiplexed hex 7-segment driver shows the result. Sits between the board I/O (switches, one push-button, 7-seg, LEDs) and nothing else; it is the top-level datapath of the ALU demo.

## Interface
- `W`, 4: operand width in bits (2..16); `NDIG = (W+3)/4` display digits (derived localparam).
- `REFRESH_DIV`, 50000: clk cycles per display digit slot (≥2).
- `DEB_CYCLES`, 500000: stable-low cycles required for a press (used only with `ULA_DEBOUNCE_EN`; ≥2).
- `clk`  in  1  system clock (50 MHz on board).
- `rst_n`  in  1  asynchronous, active-low reset; single clock domain `clk`.
- `sw_entrada`  in  W  operand/opcode switches; opcode = `sw_entrada[2:0]`.
- `botao_prox`  in  1  advance button, active-low, asynchronous to clk.
- `seg`  out  7  segments g..a (`seg[6]`=g), active-low.
- `an`  out  NDIG  digit enables, active-low, one-hot-low.
- `led_over`, `led_zero`, `led_neg`  out  1 each  result flags.
- `leds_debug`  out  3  current state code.

## Operation
- States (code): IDLE 0, LOAD_A 1, LOAD_B 2, LOAD_OP 3, EXEC 4. Each press moves one step: IDLE→LOAD_A→LOAD_B→LOAD_OP→EXEC→IDLE.
- Press leaving LOAD_A captures `A=sw_entrada`; leaving LOAD_B captures `B`; leaving LOAD_OP captures `op=sw_entrada[2:0]` and registers result + flags from A, B, op.
- Ops (A, B unsigned): 000 A+B; 001 A−B; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 A<<1; 111 A>>1.
- Add: W+1-bit sum; result = low W bits; `over` = carry out.
- Sub: if A≥B, result = A−B and `neg`=0; else result = B−A (magnitude) and `neg`=1; `over`=0.
- Shl: `over` = A[W-1]. All logic ops and shr: `over`=0, `neg`=0.
- `zero` = (result == 0), evaluated on the stored magnitude.
- Flag LEDs drive registered flags only in EXEC; 0 in every other state.
- Display source: IDLE → all digits blank (`seg`=7'h7F). LOAD_A/B/OP → live `sw_entrada` in hex. EXEC → result in hex. Digit k shows nibble k (zero-extended); upper unused bits read 0.
- Leaving EXEC (press) clears A, B, op, result and flags to 0.

## Timing
- `botao_prox` passes a 2-FF synchroniser (reset value 1). A press pulse is one clk wide on the 1→0 transition of the synchronised/filtered level. Holding the button produces exactly one pulse.
- FSM state and captured registers update on the clk edge where the pulse is high. Press-to-`leds_debug` change is 3 cycles without debounce.
- Result/flags are visible the cycle after EXEC is entered (same edge as the state change).
- Digit scan: `an` rotates digit 0→NDIG−1→0, one slot per REFRESH_DIV cycles. `seg` changes on the same edge as `an`.
- Reset values: state IDLE, `leds_debug`=0, flags 0, `seg`=7'h7F, `an`=all ones except `an[0]`=0, scan counter 0, A/B/op/result 0.
- Reset asserted mid-sequence returns to IDLE at once; captured data is lost. Button held low through reset release yields exactly one press 2 cycles later (no debounce).
- `sw_entrada` is not synchronised; it must be stable at the press edge.

## Configuration
- `ULA_DEBOUNCE_EN` defined: the synchronised level must stay low for DEB_CYCLES consecutive cycles before the filtered level goes low. A return high of ≥1 cycle restarts the count. Release is filtered identically. Press latency = 2 + DEB_CYCLES + 1 cycles.
- Undefined: filtered level = synchronised level; no counter is instantiated.

## Structure
- Package `ula_pkg`: state codes, opcode constants, hex→7-seg function (active-low).
- Sub-module `botao_sync`: synchroniser, optional debounce, falling-edge pulse. Top holds the FSM, ALU, result registers and display mux.

## Test plan
- W=4: press, A=3, B=1, op=000, press ×4 → `leds_debug`=4, result 4, digit0 `seg`=7'h19, flags 0.
- W=4: A=2, B=5, op=001 → result 3, `led_neg`=1, `led_zero`=0; next press → IDLE, flags 0.
- W=4: A=15, B=1, op=000 → result 0, `led_over`=1, `led_zero`=1.
- W=8, REFRESH_DIV=4: A=8'hA5, op=110 → result 8'h4A, `over`=1. `an` alternates 2'b10/2'b01 every 4 cycles, showing 'A' then '4'.
- Reset pulse while in LOAD_B (A=7 stored) → IDLE, blank display. A full re-run with A=1, B=1, op=001 → `zero`=1.
- `ULA_DEBOUNCE_EN`, DEB_CYCLES=4: a 3-cycle low glitch gives no state change. A 10-cycle low press advances exactly one state.

Source files
------------

// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the parametrised ALU sequencer:
//   - state_e : FSM state codes (value is what leds_debug shows)
//   - op_e    : 3-bit opcode encoding of the 8-operation ALU
//   - SEG_BLANK / hex_to_seg : active-low 7-segment encoding, seg[6]=g .. seg[0]=a
// -----------------------------------------------------------------------------
package ula_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_LOAD_OP = 3'd3,
    ST_EXEC    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit to active-low segment pattern, bit order g..a
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg_on;
    case (nib)
      4'h0:    seg_on = 7'h3F;
      4'h1:    seg_on = 7'h06;
      4'h2:    seg_on = 7'h5B;
      4'h3:    seg_on = 7'h4F;
      4'h4:    seg_on = 7'h66;
      4'h5:    seg_on = 7'h6D;
      4'h6:    seg_on = 7'h7D;
      4'h7:    seg_on = 7'h07;
      4'h8:    seg_on = 7'h7F;
      4'h9:    seg_on = 7'h6F;
      4'hA:    seg_on = 7'h77;
      4'hB:    seg_on = 7'h7C;
      4'hC:    seg_on = 7'h39;
      4'hD:    seg_on = 7'h5E;
      4'hE:    seg_on = 7'h79;
      4'hF:    seg_on = 7'h71;
      default: seg_on = 7'h00;
    endcase
    return ~seg_on;
  endfunction

endpackage

// File: rtl/ula_fsm_param_botao_sync.sv
// -----------------------------------------------------------------------------
// botao_sync
// Turns the asynchronous active-low push-button into a single-cycle press
// pulse: 2-FF synchroniser (reset to released), optional debounce filter,
// then falling-edge detection on the filtered level.
//
// Optional feature macro: ULA_DEBOUNCE_EN
//   defined   -> the synchronised level must hold a new value for DEB_CYCLES
//                consecutive cycles before the filtered level follows it
//                (applies to both press and release).
//   undefined -> filtered level is the synchronised level, no counter.
//
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   btn_n       in  raw button, active-low, asynchronous to clk
//   press_pulse out one-cycle pulse on the filtered 1->0 transition
// -----------------------------------------------------------------------------
module botao_sync #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  logic [1:0] sync_r;
  logic       filt_s;
  logic       prev_r;

  if (DEB_CYCLES < 2) begin : g_deb_check
    $error("botao_sync: DEB_CYCLES must be at least 2");
  end

  // Two-stage synchroniser; resets to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], btn_n};
    end
  end

`ifdef ULA_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_r;
  logic             filt_r;

  // Count consecutive cycles the synchronised level differs from the filtered
  // one; any return to agreement restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      filt_r    <= 1'b1;
    end else if (sync_r[1] == filt_r) begin
      deb_cnt_r <= {DEB_W{1'b0}};
    end else if (deb_cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      filt_r    <= sync_r[1];
    end else begin
      deb_cnt_r <= deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
    end
  end

  assign filt_s = filt_r;
`else
  assign filt_s = sync_r[1];
`endif

  // Previous filtered level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= filt_s;
    end
  end

  // Kept combinational so the FSM acts on the edge right after the level drops
  assign press_pulse = prev_r & ~filt_s;

endmodule

// File: rtl/ula_fsm_param.sv
// -----------------------------------------------------------------------------
// ula_fsm_param
// Top-level datapath of the ALU demo: a five-state sequencer stepped by a
// push-button captures A, B and the opcode from the switches, registers the
// ALU result and flags, and drives a multiplexed hex 7-segment display.
//
// Optional feature macro: ULA_DEBOUNCE_EN (button debounce, see botao_sync).
//
// Parameters:
//   W           operand width (2..16); NDIG = (W+3)/4 display digits
//   REFRESH_DIV clk cycles per digit slot (>=2)
//   DEB_CYCLES  debounce length in cycles (only with ULA_DEBOUNCE_EN)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sw_entrada   operand / opcode switches (opcode = sw_entrada[2:0])
//   botao_prox   advance button, active-low, asynchronous
//   seg          segments g..a, active-low
//   an           digit enables, active-low one-hot
//   led_over/led_zero/led_neg  result flags (non-zero only in EXEC)
//   leds_debug   current state code
// -----------------------------------------------------------------------------
module ula_fsm_param
  import ula_pkg::*;
#(
  parameter  int W           = 4,
  parameter  int REFRESH_DIV = 50000,
  parameter  int DEB_CYCLES  = 500000,
  localparam int NDIG        = (W + 3) / 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    sw_entrada,
  input  logic            botao_prox,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an,
  output logic            led_over,
  output logic            led_zero,
  output logic            led_neg,
  output logic [2:0]      leds_debug
);

  localparam int DISP_W = NDIG * 4;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (W < 2 || W > 16) begin : g_w_check
    $error("ula_fsm_param: W must be in 2..16");
  end
  if (REFRESH_DIV < 2) begin : g_div_check
    $error("ula_fsm_param: REFRESH_DIV must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic press_s;

  botao_sync #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_botao_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (botao_prox),
    .press_pulse (press_s)
  );

  // ---------------------------------------------------------------------------
  // ALU (combinational, evaluated on captured A/B and the live opcode switches)
  // ---------------------------------------------------------------------------
  state_e         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   result_r;
  logic           over_r;
  logic           zero_r;
  logic           neg_r;

  logic [2:0]     op_sel_s;
  logic [W:0]     sum_s;
  logic [W-1:0]   alu_res_s;
  logic           alu_over_s;
  logic           alu_neg_s;
  logic           alu_zero_s;

  // Zero-extends when W < 3 so narrow builds still get a full opcode
  assign op_sel_s = 3'(sw_entrada);
  assign sum_s    = {1'b0, a_r} + {1'b0, b_r};

  // Operation select; subtraction stores the magnitude and flags the sign
  always_comb begin
    alu_res_s  = {W{1'b0}};
    alu_over_s = 1'b0;
    alu_neg_s  = 1'b0;
    case (op_sel_s)
      OP_ADD: begin
        alu_res_s  = sum_s[W-1:0];
        alu_over_s = sum_s[W];
      end
      OP_SUB: begin
        if (a_r >= b_r) begin
          alu_res_s = a_r - b_r;
          alu_neg_s = 1'b0;
        end else begin
          alu_res_s = b_r - a_r;
          alu_neg_s = 1'b1;
        end
      end
      OP_AND:  alu_res_s = a_r & b_r;
      OP_OR:   alu_res_s = a_r | b_r;
      OP_XOR:  alu_res_s = a_r ^ b_r;
      OP_NOT:  alu_res_s = ~a_r;
      OP_SHL: begin
        alu_res_s  = {a_r[W-2:0], 1'b0};
        alu_over_s = a_r[W-1];
      end
      OP_SHR:  alu_res_s = {1'b0, a_r[W-1:1]};
      default: alu_res_s = {W{1'b0}};
    endcase
  end

  assign alu_zero_s = (alu_res_s == {W{1'b0}});

  // ---------------------------------------------------------------------------
  // Sequencer: one step per press. The opcode is not held; only its effect,
  // the registered result and flags, is kept. Flags are only ever set on
  // entry to EXEC and cleared on exit, so they can drive the LEDs directly.
  // ---------------------------------------------------------------------------
  // State, operand capture, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      result_r <= {W{1'b0}};
      over_r   <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
    end else if (press_s) begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_LOAD_A;
        end
        ST_LOAD_A: begin
          a_r     <= sw_entrada;
          state_r <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          b_r     <= sw_entrada;
          state_r <= ST_LOAD_OP;
        end
        ST_LOAD_OP: begin
          result_r <= alu_res_s;
          over_r   <= alu_over_s;
          zero_r   <= alu_zero_s;
          neg_r    <= alu_neg_s;
          state_r  <= ST_EXEC;
        end
        default: begin
          // EXEC and any illegal code: drop everything and return to IDLE
          a_r      <= {W{1'b0}};
          b_r      <= {W{1'b0}};
          result_r <= {W{1'b0}};
          over_r   <= 1'b0;
          zero_r   <= 1'b0;
          neg_r    <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign leds_debug = state_r;
  assign led_over   = over_r;
  assign led_zero   = zero_r;
  assign led_neg    = neg_r;

  // ---------------------------------------------------------------------------
  // Display multiplexer. an/seg are registered from the *next* digit index so
  // both switch on the same edge; seg also tracks live switches in LOAD states.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  scan_cnt_r;
  logic [DIG_W-1:0]  dig_r;
  logic [NDIG-1:0]   an_r;
  logic [6:0]        seg_r;

  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [DIG_W-1:0]  dig_nxt_s;
  logic [NDIG-1:0]   an_nxt_s;
  logic [W-1:0]      disp_val_s;
  logic              disp_blank_s;
  logic [DISP_W-1:0] disp_ext_s;
  logic [3:0]        nib_s;
  logic [6:0]        seg_nxt_s;

  // Slot counter and digit index advance
  always_comb begin
    cnt_nxt_s = scan_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    dig_nxt_s = dig_r;
    if (scan_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      if (dig_r == DIG_W'(NDIG - 1)) begin
        dig_nxt_s = {DIG_W{1'b0}};
      end else begin
        dig_nxt_s = dig_r + {{(DIG_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dig_nxt_s = dig_r;
    end
  end

  // Display source per state
  always_comb begin
    disp_val_s   = {W{1'b0}};
    disp_blank_s = 1'b1;
    case (state_r)
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: begin
        disp_val_s   = sw_entrada;
        disp_blank_s = 1'b0;
      end
      ST_EXEC: begin
        disp_val_s   = result_r;
        disp_blank_s = 1'b0;
      end
      default: begin
        disp_val_s   = {W{1'b0}};
        disp_blank_s = 1'b1;
      end
    endcase
  end

  assign disp_ext_s = DISP_W'(disp_val_s);

  // Nibble selection and digit enable decode for the upcoming slot
  always_comb begin
    nib_s    = 4'h0;
    an_nxt_s = {NDIG{1'b1}};
    for (int k = 0; k < NDIG; k++) begin
      if (dig_nxt_s == DIG_W'(k)) begin
        nib_s       = disp_ext_s[k*4 +: 4];
        an_nxt_s[k] = 1'b0;
      end else begin
        an_nxt_s[k] = 1'b1;
      end
    end
  end

  assign seg_nxt_s = disp_blank_s ? SEG_BLANK : hex_to_seg(nib_s);

  // Scan registers and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= {CNT_W{1'b0}};
      dig_r      <= {DIG_W{1'b0}};
      an_r       <= {{(NDIG-1){1'b1}}, 1'b0};
      seg_r      <= SEG_BLANK;
    end else begin
      scan_cnt_r <= cnt_nxt_s;
      dig_r      <= dig_nxt_s;
      an_r       <= an_nxt_s;
      seg_r      <= seg_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;

endmodule

// File: tb/tb_ula_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_ula_fsm_param
// Self-checking bench for ula_fsm_param at W=8, REFRESH_DIV=4, DEB_CYCLES=4.
// Expected ALU results are pushed to a scoreboard queue when the opcode is
// driven and popped when the sequencer reaches EXEC. The displayed result is
// read back through the digit scan and compared against a 7-seg table.
// -----------------------------------------------------------------------------
module tb_ula_fsm_param;

  localparam int W   = 8;
  localparam int RD  = 4;
  localparam int DEB = 4;
`ifdef ULA_DEBOUNCE_EN
  localparam int PRESS_LAT = 2 + DEB + 1;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_entrada = 8'h00;
  logic         botao_prox = 1'b1;
  logic [6:0]   seg;
  logic [1:0]   an;
  logic         led_over;
  logic         led_zero;
  logic         led_neg;
  logic [2:0]   leds_debug;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       ov;
    logic       z;
    logic       n;
  } exp_t;

  exp_t exp_q[$];

  // Active-low patterns g..a for hex 0..F
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ula_fsm_param #(
    .W           (W),
    .REFRESH_DIV (RD),
    .DEB_CYCLES  (DEB)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_entrada (sw_entrada),
    .botao_prox (botao_prox),
    .seg        (seg),
    .an         (an),
    .led_over   (led_over),
    .led_zero   (led_zero),
    .led_neg    (led_neg),
    .leds_debug (leds_debug)
  );

  always #5 clk = ~clk;

  // Reference ALU
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    logic [8:0] s;
    e = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; e.ov = s[8]; end
      3'd1: begin
        if (a >= b) e.res = a - b;
        else begin e.res = b - a; e.n = 1'b1; end
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~a;
      3'd6: begin e.res = {a[6:0], 1'b0}; e.ov = a[7]; end
      default: e.res = {1'b0, a[7:1]};
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Press, hold, release; returns cycles from press to a leds_debug change
  task automatic press(output int lat);
    logic [2:0] old;
    old = leds_debug;
    botao_prox = 1'b0;
    lat = 0;
    while (leds_debug === old && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (4) @(negedge clk);
    botao_prox = 1'b1;
    repeat (PRESS_LAT + 2) @(negedge clk);
  endtask

  // Capture the segment pattern shown on each digit over several scan slots
  task automatic read_disp(output logic [6:0] d0, output logic [6:0] d1);
    d0 = 7'bx;
    d1 = 7'bx;
    for (int i = 0; i < 5 * RD; i++) begin
      @(negedge clk);
      if (an === 2'b10) d0 = seg;
      else if (an === 2'b01) d1 = seg;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full IDLE -> EXEC sequence; scoreboard compares flags and displayed result
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input string nm);
    int lat;
    exp_t e;
    logic [6:0] d0, d1;
    press(lat);
    checks++;
    if (leds_debug !== 3'd1) begin errors++; $display("FAIL %s to_load_a: got %0d want 1", nm, leds_debug); end
    sw_entrada = a;
    press(lat);
    checks++;
    if (leds_debug !== 3'd2) begin errors++; $display("FAIL %s to_load_b: got %0d want 2", nm, leds_debug); end
    sw_entrada = b;
    press(lat);
    checks++;
    if (leds_debug !== 3'd3) begin errors++; $display("FAIL %s to_load_op: got %0d want 3", nm, leds_debug); end
    sw_entrada = {5'b00000, op};
    exp_q.push_back(model(a, b, op));
    press(lat);
    checks++;
    if (leds_debug !== 3'd4 || lat != PRESS_LAT) begin
      errors++;
      $display("FAIL %s to_exec: got state %0d lat %0d want state 4 lat %0d", nm, leds_debug, lat, PRESS_LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if ({led_over, led_zero, led_neg} !== {e.ov, e.z, e.n}) begin
      errors++;
      $display("FAIL %s flags: got ovr/zero/neg %b%b%b want %b%b%b", nm, led_over, led_zero, led_neg, e.ov, e.z, e.n);
    end
    read_disp(d0, d1);
    checks++;
    if (d0 !== seg_tab[e.res[3:0]] || d1 !== seg_tab[e.res[7:4]]) begin
      errors++;
      $display("FAIL %s display: got d0=%h d1=%h want d0=%h d1=%h (result %h)", nm, d0, d1,
               seg_tab[e.res[3:0]], seg_tab[e.res[7:4]], e.res);
    end
  endtask

  // Leave EXEC: back to IDLE with flags cleared and display blank
  task automatic exit_exec(input string nm);
    int lat;
    logic [6:0] d0, d1;
    press(lat);
    checks++;
    if (leds_debug !== 3'd0 || {led_over, led_zero, led_neg} !== 3'b000) begin
      errors++;
      $display("FAIL %s exit: got state %0d flags %b%b%b want state 0 flags 000", nm, leds_debug, led_over, led_zero, led_neg);
    end
    read_disp(d0, d1);
    checks++;
    if (d0 !== 7'h7F || d1 !== 7'h7F) begin
      errors++;
      $display("FAIL %s idle_blank: got d0=%h d1=%h want 7f 7f", nm, d0, d1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds_debug !== 3'd0 || seg !== 7'h7F || an !== 2'b10 || {led_over, led_zero, led_neg} !== 3'b000) begin
      errors++;
      $display("FAIL reset: got state %0d seg %h an %b flags %b%b%b want 0 7f 10 000",
               leds_debug, seg, an, led_over, led_zero, led_neg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_live_display();
    int lat;
    logic [6:0] d0, d1;
    press(lat);
    checks++;
    if (lat != PRESS_LAT) begin errors++; $display("FAIL press_latency: got %0d want %0d", lat, PRESS_LAT); end
    sw_entrada = 8'h3C;
    read_disp(d0, d1);
    checks++;
    if (d0 !== seg_tab[12] || d1 !== seg_tab[3]) begin
      errors++;
      $display("FAIL live_sw: got d0=%h d1=%h want %h %h", d0, d1, seg_tab[12], seg_tab[3]);
    end
    do_reset();
  endtask

  task automatic test_add();
    run_op(8'h03, 8'h01, 3'd0, "add_3_1");
    checks++;
    if (seg_tab[4] !== 7'h19 || leds_debug !== 3'd4) begin
      errors++;
      $display("FAIL add_digit0: got state %0d want 4", leds_debug);
    end
    exit_exec("add_3_1");
    run_op(8'hFF, 8'h01, 3'd0, "add_carry");
    exit_exec("add_carry");
  endtask

  task automatic test_sub();
    run_op(8'h02, 8'h05, 3'd1, "sub_neg");
    exit_exec("sub_neg");
    run_op(8'h96, 8'h3C, 3'd1, "sub_pos");
    exit_exec("sub_pos");
  endtask

  task automatic test_shl_scan();
    int n;
    logic [1:0] prev;
    run_op(8'hA5, 8'h00, 3'd6, "shl_a5");
    prev = an;
    n = 0;
    while (an === prev && n < 10) begin @(negedge clk); n++; end
    for (int s = 0; s < 3; s++) begin
      prev = an;
      n = 0;
      while (an === prev && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (n != RD || an !== {prev[0], prev[1]}) begin
        errors++;
        $display("FAIL scan_period: got %0d cycles an=%b want %0d cycles an=%b", n, an, RD, {prev[0], prev[1]});
      end
      checks++;
      if ((an === 2'b10 && seg !== seg_tab[10]) || (an === 2'b01 && seg !== seg_tab[4])) begin
        errors++;
        $display("FAIL scan_seg: got an=%b seg=%h", an, seg);
      end
    end
    exit_exec("shl_a5");
  endtask

  task automatic test_back_to_back();
    for (int op = 2; op < 8; op++) begin
      run_op(8'h96, 8'h3C, 3'(op), $sformatf("op%0d", op));
      exit_exec($sformatf("op%0d", op));
    end
    run_op(8'h01, 8'hFF, 3'd5, "not_fe");
    exit_exec("not_fe");
    run_op(8'hFF, 8'h00, 3'd5, "not_zero");
    exit_exec("not_zero");
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [6:0] d0, d1;
    press(lat);
    sw_entrada = 8'h07;
    press(lat);
    checks++;
    if (leds_debug !== 3'd2) begin errors++; $display("FAIL mid_setup: got %0d want 2", leds_debug); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (leds_debug !== 3'd0 || seg !== 7'h7F) begin
      errors++;
      $display("FAIL mid_reset: got state %0d seg %h want 0 7f", leds_debug, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_disp(d0, d1);
    checks++;
    if (d0 !== 7'h7F || d1 !== 7'h7F) begin
      errors++;
      $display("FAIL mid_blank: got d0=%h d1=%h want 7f 7f", d0, d1);
    end
    run_op(8'h01, 8'h01, 3'd1, "rerun_zero");
    exit_exec("rerun_zero");
  endtask

  task automatic test_hold_through_reset();
    int lat;
    @(negedge clk);
    rst_n = 1'b0;
    botao_prox = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (leds_debug === 3'd0 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat != PRESS_LAT || leds_debug !== 3'd1) begin
      errors++;
      $display("FAIL held_reset: got lat %0d state %0d want lat %0d state 1", lat, leds_debug, PRESS_LAT);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (leds_debug !== 3'd1) begin errors++; $display("FAIL held_single: got %0d want 1", leds_debug); end
    botao_prox = 1'b1;
    repeat (PRESS_LAT + 2) @(negedge clk);
    do_reset();
  endtask

`ifdef ULA_DEBOUNCE_EN
  task automatic test_debounce();
    botao_prox = 1'b0;
    repeat (3) @(negedge clk);
    botao_prox = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (leds_debug !== 3'd0) begin errors++; $display("FAIL deb_glitch: got %0d want 0", leds_debug); end
    botao_prox = 1'b0;
    repeat (10) @(negedge clk);
    botao_prox = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (leds_debug !== 3'd1) begin errors++; $display("FAIL deb_press: got %0d want 1", leds_debug); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_live_display();
    test_add();
    test_sub();
    test_shl_scan();
    test_back_to_back();
    test_reset_mid();
    test_hold_through_reset();
`ifdef ULA_DEBOUNCE_EN
    test_debounce();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
